// File: rtl/lbus_master_if.sv
// Command, response and local-bus signal bundle for lbus_master.
// The master modport is the initiator's view; slave is the view of the
// surrounding logic (command source, response sink and bus responders).
interface lbus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [7:0]  lb_addr;
  logic [31:0] lb_wdata;
  logic        lb_read;
  logic        lb_write;
  logic [31:0] lb_rdata;
  logic        lb_ack;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, lb_rdata, lb_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           lb_addr, lb_wdata, lb_read, lb_write
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, lb_rdata, lb_ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           lb_addr, lb_wdata, lb_read, lb_write
  );
endinterface

// File: rtl/lbus_master.sv
// Local-bus initiator: turns one upstream command into a single-cycle
// read/write strobe and returns read data or a write completion.
//
//  state | meaning
//  IDLE  | cmd_ready high, waiting for a command
//  STRB  | one-cycle lb_read or lb_write strobe
//  WAIT  | counting read latency, or waiting for lb_ack / timeout
//  RSP   | response presented until rsp_ready
//
// Wait counter: in the cycle that is k cycles after the strobe, cnt_q == k.
// Fixed latency reads sample lb_rdata when cnt_q == RD_LAT. Acking
// responders get their last chance when cnt_q == TIMEOUT; an ack in that
// cycle still completes without error.
// Fixed-latency writes need no wait and go straight from STRB to RSP.
module lbus_master #(
  parameter int unsigned RD_LAT  = 2,
  parameter bit          USE_ACK = 1'b0,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  lbus_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  localparam logic [7:0] RD_LAT_C  = 8'(RD_LAT);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        init_q;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  cnt_q;

  logic        accept_c;
  logic        capture_c;
  logic        timeout_c;

  // init_q keeps cmd_ready low until the first clock after reset release
  assign accept_c = (state_q == IDLE) && init_q && bus.cmd_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic plus the capture/timeout decisions made on the way out of STRB/WAIT
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) state_d = STRB;
      end
      STRB: begin
        if (USE_ACK) begin
          if (bus.lb_ack) begin
            capture_c = !wr_q;
            state_d   = RSP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = wr_q ? RSP : WAIT;
        end
      end
      WAIT: begin
        if (USE_ACK) begin
          if (bus.lb_ack) begin
            capture_c = !wr_q;
            state_d   = RSP;
          end else if (cnt_q == TIMEOUT_C) begin
            timeout_c = 1'b1;
            state_d   = RSP;
          end
        end else if (cnt_q == RD_LAT_C) begin
          capture_c = !wr_q;
          state_d   = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; strobes exist only in STRB
  always_comb begin
    bus.cmd_ready = (state_q == IDLE) && init_q;
    bus.lb_read   = (state_q == STRB) && !wr_q;
    bus.lb_write  = (state_q == STRB) && wr_q;
    bus.lb_addr   = addr_q;
    bus.lb_wdata  = wdata_q;
    bus.rsp_valid = (state_q == RSP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // Command latch, wait counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      init_q <= 1'b1;
      if (accept_c) begin
        wr_q    <= bus.cmd_write;
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_write ? bus.cmd_wdata : 32'h0;
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
      if (state_q == STRB)      cnt_q <= 8'd1;
      else if (state_q == WAIT) cnt_q <= cnt_q + 8'd1;
      if (capture_c) rdata_q <= bus.lb_rdata;
      if (timeout_c) err_q   <= 1'b1;
    end
  end

endmodule
